// File: rtl/instr_fetch_stage_if.sv
// Redirect, instruction-memory and decode-side handshake signals of the fetch stage.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  imem_req_valid;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, in-order word fetches, and a small queue of
// {pc, instr} entries handed to decode over a valid/ready handshake.
module instr_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input logic clk,
  input logic rst,
  instr_fetch_stage_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(2 * DEPTH + 1);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] q_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] q_instr [DEPTH];
  logic [DEPTH-1:0]      q_filled;
  logic [PTR_W-1:0]      alloc_ptr;
  logic [PTR_W-1:0]      fill_ptr;
  logic [PTR_W-1:0]      head_ptr;
  logic [PTR_W:0]        alloc_cnt;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      drop;

  logic req_fire;
  logic rsp_fire;
  logic pop;

  // Allocated entries count requests still in memory as well as buffered ones,
  // so the queue always has room for every response that will be kept.
  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (alloc_cnt < (PTR_W + 1)'(DEPTH));
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = q_filled[head_ptr];
  assign bus.out_pc         = q_pc[head_ptr];
  assign bus.out_instr      = q_instr[head_ptr];

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid && (inflight != '0);
  assign pop      = q_filled[head_ptr] && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      q_filled  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      inflight  <= '0;
      drop      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      if (bus.redirect_valid) begin
        // Responses still owed by memory after this cycle belong to the old path.
        pc        <= {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
        q_filled  <= '0;
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        head_ptr  <= '0;
        alloc_cnt <= '0;
        drop      <= inflight - CNT_W'(rsp_fire);
        for (int i = 0; i < DEPTH; i++) begin
          q_pc[i]    <= '0;
          q_instr[i] <= '0;
        end
      end else begin
        if (req_fire) begin
          q_pc[alloc_ptr]     <= pc;
          q_filled[alloc_ptr] <= 1'b0;
          alloc_ptr           <= alloc_ptr + PTR_W'(1);
          pc                  <= pc + DATA_WIDTH'(4);
        end
        if (rsp_fire) begin
          if (drop != '0) begin
            drop <= drop - CNT_W'(1);
          end else begin
            q_instr[fill_ptr]  <= bus.imem_rsp_data;
            q_filled[fill_ptr] <= 1'b1;
            fill_ptr           <= fill_ptr + PTR_W'(1);
          end
        end
        if (pop) begin
          q_filled[head_ptr] <= 1'b0;
          head_ptr           <= head_ptr + PTR_W'(1);
        end
        alloc_cnt <= alloc_cnt + (PTR_W + 1)'(req_fire) - (PTR_W + 1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: in-order latency memory model plus a scoreboard that
// predicts the PC stream decode should see from the fetch and redirect rules.
module tb_instr_fetch_stage;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk;
  logic rst;

  instr_fetch_stage_if #(.DATA_WIDTH(DW)) bus ();

  instr_fetch_stage #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] salt;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          alloc_m;
  int          consumed = 0;
  int          accepted = 0;
  logic [31:0] last_out_pc;
  logic        last_rv;
  logic [31:0] last_addr;
  bit          junk_next = 0;
  bit          arm_combo = 0;
  bit          combo_hit = 0;
  logic [31:0] combo_target;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_pc  = RESET_PC;
    exp_req = RESET_PC;
    alloc_m = 0;
    mq_addr.delete();
    mq_due.delete();
  endtask

  // One clock cycle, entered and left at posedge+1; outputs sampled on the negedge.
  task automatic cycle();
    int lat;
    if (junk_next) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
      junk_next          = 0;
    end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    if (arm_combo && bus.out_valid && bus.imem_rsp_valid) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = combo_target;
      arm_combo          = 0;
      combo_hit          = 1;
    end
    @(negedge clk);
    last_rv   = bus.imem_req_valid;
    last_addr = bus.imem_req_addr;
    check("req_valid", {31'b0, last_rv}, {31'b0, (!bus.redirect_valid && alloc_m < DEPTH)});
    if (last_rv) check("req_addr", last_addr, exp_req);
    if (bus.out_valid && bus.out_ready) begin
      check("out_pc", bus.out_pc, exp_pc);
      check("out_instr", bus.out_instr, memf(exp_pc));
      last_out_pc = bus.out_pc;
      exp_pc      = exp_pc + 32'd4;
      consumed++;
      alloc_m--;
    end
    if (last_rv && bus.imem_req_ready) begin
      lat = (lat_min == lat_max) ? lat_min : int'($urandom_range(lat_max, lat_min));
      mq_addr.push_back(last_addr);
      mq_due.push_back(cyc + lat);
      exp_req = exp_req + 32'd4;
      alloc_m++;
      accepted++;
    end
    if (bus.redirect_valid) begin
      exp_pc  = {bus.redirect_pc[31:2], 2'b00};
      exp_req = exp_pc;
      alloc_m = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && consumed < target; i++) cycle();
    check(tag, {31'b0, (consumed >= target)}, 32'd1);
  endtask

  task automatic drain();
    bus.imem_req_ready = 1'b0;
    bus.out_ready      = 1'b1;
    applyStimulus(12);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_out_pc"}, bus.out_pc, 32'd0);
    check({tag, "_out_instr"}, bus.out_instr, 32'd0);
  endtask

  initial begin
    int c0;
    int a0;
    salt               = $urandom;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.out_ready      = 1'b0;
    #2;
    checkOutput("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();

    // Streaming from RESET_PC with a one-cycle memory.
    lat_min = 1; lat_max = 1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    run_until("stream", consumed + 12, 80);

    // Backpressure: only DEPTH fetches may be accepted while decode stalls.
    drain();
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    a0 = accepted;
    applyStimulus(10);
    check("bp_accepted", accepted - a0, DEPTH);
    check("bp_full_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    run_until("bp_release", consumed + 6, 40);

    // Redirect with two fetches outstanding on a three-cycle memory.
    drain();
    lat_min = 3; lat_max = 3;
    bus.imem_req_ready = 1'b1;
    applyStimulus(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2003;
    cycle();
    cycle();
    check("redir_req_valid", {31'b0, last_rv}, 32'd1);
    check("redir_req_addr", last_addr, 32'h0000_2000);
    c0 = consumed;
    run_until("redir_first", c0 + 1, 30);
    check("redir_first_pc", last_out_pc, 32'h0000_2000);
    run_until("redir_stream", c0 + 4, 40);

    // Redirect coinciding with a decode handoff and a memory response.
    lat_min = 1; lat_max = 1;
    combo_target = 32'h0000_4008;
    combo_hit    = 0;
    arm_combo    = 1;
    for (int i = 0; i < 40 && !combo_hit; i++) cycle();
    arm_combo = 0;
    check("combo_hit", {31'b0, combo_hit}, 32'd1);
    cycle();
    check("combo_req_addr", last_addr, 32'h0000_4008);
    c0 = consumed;
    run_until("combo_first", c0 + 1, 30);
    check("combo_first_pc", last_out_pc, 32'h0000_4008);

    // Address wrap at the top of the space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    c0 = consumed;
    run_until("wrap", c0 + 2, 30);
    check("wrap_pc", last_out_pc, 32'h0000_0000);

    // Random traffic: latency, both readies and redirects all vary.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.out_ready      = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom;
      end
      cycle();
    end
    c0 = consumed;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    run_until("random_tail", c0 + 4, 60);

    // Asynchronous reset in the middle of a burst, then a stray late response.
    lat_min = 2; lat_max = 2;
    bus.out_ready = 1'b0;
    applyStimulus(8);
    check("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst                = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    #1;
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    junk_next     = 1;
    bus.out_ready = 1'b1;
    c0 = consumed;
    cycle();
    check("restart_addr", last_addr, RESET_PC);
    run_until("restart_first", c0 + 1, 30);
    check("restart_first_pc", last_out_pc, RESET_PC);
    run_until("restart_stream", c0 + 5, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
